// File: rtl/cgra_mem_arbiter.sv
// Round-robin arbiter and transaction sequencer giving 4 CGRA PEs turns on one
// single-ported shared memory; all outputs are registered.
module cgra_mem_arbiter #(
  parameter int N_PE   = 4,
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_PE-1:0]   pe_req,
  input  logic [N_PE-1:0]   pe_we,
  input  logic [N_PE*AW-1:0] pe_addr,
  input  logic [N_PE*DW-1:0] pe_wdata,
  output logic [N_PE-1:0]   pe_ack,
  output logic [DW-1:0]     pe_rdata,
  output logic [N_PE-1:0]   grant,
  output logic              busy,
  output logic              mem_en,
  output logic              mem_we,
  output logic [AW-1:0]     mem_addr,
  output logic [DW-1:0]     mem_wdata,
  input  logic [DW-1:0]     mem_rdata
);

  localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t          state_r, state_s;
  logic [1:0]      rr_ptr_r, rr_ptr_s;
  logic            we_r, we_s;
  logic [CW-1:0]   cnt_r, cnt_s;
  logic [N_PE-1:0] grant_s, ack_s;
  logic [DW-1:0]   rdata_s;
  logic            mem_en_s, mem_we_s, busy_s;
  logic [AW-1:0]   addr_s;
  logic [DW-1:0]   wdata_s;
  logic [2:0]      pick_s;
  logic [1:0]      win_s;

  // {found, index} of the first requester at or after ptr, wrapping 3 -> 0
  function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (req[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  // Winner selection and next-state / next-output logic
  always_comb begin
    pick_s   = rr_pick(pe_req, rr_ptr_r);
    win_s    = pick_s[1:0];
    state_s  = state_r;
    rr_ptr_s = rr_ptr_r;
    we_s     = we_r;
    cnt_s    = cnt_r;
    grant_s  = grant;
    ack_s    = {N_PE{1'b0}};
    rdata_s  = pe_rdata;
    mem_en_s = 1'b0;
    mem_we_s = 1'b0;
    addr_s   = mem_addr;
    wdata_s  = mem_wdata;
    case (state_r)
      IDLE: begin
        if (pick_s[2]) begin
          grant_s  = N_PE'(4'b0001 << win_s);
          we_s     = pe_we[win_s];
          addr_s   = pe_addr[int'(win_s)*AW +: AW];
          wdata_s  = pe_wdata[int'(win_s)*DW +: DW];
          rr_ptr_s = win_s + 2'd1;
          mem_en_s = 1'b1;
          mem_we_s = pe_we[win_s];
          state_s  = ISSUE;
        end else begin
          grant_s  = {N_PE{1'b0}};
        end
      end
      ISSUE: begin
        if (we_r) begin
          ack_s   = grant;
          state_s = DONE;
        end else begin
          cnt_s   = CW'(RD_LAT - 1);
          state_s = WAIT;
        end
      end
      WAIT: begin
        if (cnt_r == {CW{1'b0}}) begin
          rdata_s = mem_rdata;
          ack_s   = grant;
          state_s = DONE;
        end else begin
          cnt_s   = cnt_r - CW'(1);
        end
      end
      DONE: begin
        grant_s = {N_PE{1'b0}};
        state_s = IDLE;
      end
      default: begin
        grant_s = {N_PE{1'b0}};
        state_s = IDLE;
      end
    endcase
    busy_s = (state_s != IDLE);
  end

  // State and registered outputs; reset aborts any transaction in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= IDLE;
      rr_ptr_r  <= 2'd0;
      we_r      <= 1'b0;
      cnt_r     <= {CW{1'b0}};
      grant     <= {N_PE{1'b0}};
      pe_ack    <= {N_PE{1'b0}};
      pe_rdata  <= {DW{1'b0}};
      busy      <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= {AW{1'b0}};
      mem_wdata <= {DW{1'b0}};
    end else begin
      state_r   <= state_s;
      rr_ptr_r  <= rr_ptr_s;
      we_r      <= we_s;
      cnt_r     <= cnt_s;
      grant     <= grant_s;
      pe_ack    <= ack_s;
      pe_rdata  <= rdata_s;
      busy      <= busy_s;
      mem_en    <= mem_en_s;
      mem_we    <= mem_we_s;
      mem_addr  <= addr_s;
      mem_wdata <= wdata_s;
    end
  end

endmodule

// File: tb/tb_cgra_mem_arbiter.sv
// Directed self-checking bench: instance a uses RD_LAT=1, instance b RD_LAT=3;
// both share the PE-side stimulus and have their own memory models.
module tb_cgra_mem_arbiter;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [3:0]   pe_req = 4'h0;
  logic [3:0]   pe_we = 4'h0;
  logic [127:0] pe_addr = '0;
  logic [127:0] pe_wdata = '0;

  logic [3:0]  pe_ack_a, grant_a, pe_ack_b, grant_b;
  logic [31:0] pe_rdata_a, mem_addr_a, mem_wdata_a, mem_rdata_a;
  logic [31:0] pe_rdata_b, mem_addr_b, mem_wdata_b, mem_rdata_b;
  logic        busy_a, mem_en_a, mem_we_a, busy_b, mem_en_b, mem_we_b;

  logic [31:0] mem_a [0:255];
  logic [31:0] mem_b [0:255];
  logic [31:0] p1, p2, p3, rd_a;
  logic [3:0]  exp_ack;
  logic [3:0]  fair_order [0:3];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  cgra_mem_arbiter #(.N_PE(4), .AW(32), .DW(32), .RD_LAT(1)) dut_a (
    .clk(clk), .reset(reset), .pe_req(pe_req), .pe_we(pe_we), .pe_addr(pe_addr),
    .pe_wdata(pe_wdata), .pe_ack(pe_ack_a), .pe_rdata(pe_rdata_a), .grant(grant_a),
    .busy(busy_a), .mem_en(mem_en_a), .mem_we(mem_we_a), .mem_addr(mem_addr_a),
    .mem_wdata(mem_wdata_a), .mem_rdata(mem_rdata_a));

  cgra_mem_arbiter #(.N_PE(4), .AW(32), .DW(32), .RD_LAT(3)) dut_b (
    .clk(clk), .reset(reset), .pe_req(pe_req), .pe_we(pe_we), .pe_addr(pe_addr),
    .pe_wdata(pe_wdata), .pe_ack(pe_ack_b), .pe_rdata(pe_rdata_b), .grant(grant_b),
    .busy(busy_b), .mem_en(mem_en_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b),
    .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b));

  // Memory models: read data is valid only in the exact RD_LAT cycle, junk otherwise
  always @(posedge clk) begin
    if (mem_en_a && mem_we_a) mem_a[mem_addr_a[7:0]] <= mem_wdata_a;
    rd_a <= (mem_en_a && !mem_we_a) ? mem_a[mem_addr_a[7:0]] : 32'hBAD0_BAD0;
    if (mem_en_b && mem_we_b) mem_b[mem_addr_b[7:0]] <= mem_wdata_b;
    p1 <= (mem_en_b && !mem_we_b) ? mem_b[mem_addr_b[7:0]] : 32'hBAD1_BAD1;
    p2 <= p1;
    p3 <= p2;
  end
  assign mem_rdata_a = rd_a;
  assign mem_rdata_b = p3;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset  = 1'b1;
    pe_req = 4'h0;
    pe_we  = 4'h0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = 32'h0;
      mem_b[i] = 32'h0;
    end
    mem_a[8'h40] = 32'hDEAD_BEEF;
    mem_b[8'h44] = 32'h1234_5678;
    fair_order[0] = 4'b0001; fair_order[1] = 4'b1000;
    fair_order[2] = 4'b0001; fair_order[3] = 4'b1000;

    // Reset state
    @(negedge clk);
    check_val("rst_grant", grant_a, 4'h0);
    check_val("rst_ack", pe_ack_a, 4'h0);
    check_val("rst_busy", busy_a, 1'b0);
    check_val("rst_mem_en", mem_en_a, 1'b0);
    check_val("rst_mem_addr", mem_addr_a, 32'h0);
    check_val("rst_rdata", pe_rdata_a, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Single read, PE2 at 0x40
    pe_req = 4'b0100; pe_we = 4'b0000; pe_addr[2*32 +: 32] = 32'h40;
    @(negedge clk);
    check_val("rd_mem_en", mem_en_a, 1'b1);
    check_val("rd_mem_we", mem_we_a, 1'b0);
    check_val("rd_mem_addr", mem_addr_a, 32'h40);
    check_val("rd_grant", grant_a, 4'b0100);
    @(negedge clk);
    check_val("rd_ack_early", pe_ack_a, 4'b0000);
    check_val("rd_mem_en_once", mem_en_a, 1'b0);
    @(negedge clk);
    check_val("rd_ack", pe_ack_a, 4'b0100);
    check_val("rd_data", pe_rdata_a, 32'hDEAD_BEEF);
    pe_req = 4'h0;
    @(negedge clk);
    check_val("rd_idle_grant", grant_a, 4'h0);
    check_val("rd_data_hold", pe_rdata_a, 32'hDEAD_BEEF);

    // Four simultaneous writes
    do_reset();
    pe_req = 4'hF; pe_we = 4'hF;
    for (int i = 0; i < 4; i++) begin
      pe_addr[i*32 +: 32]  = 32'(i * 4);
      pe_wdata[i*32 +: 32] = 32'h1000 + 32'(i);
    end
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(negedge clk);
      exp_ack = (cyc % 3 == 2) ? 4'(4'b0001 << (cyc / 3)) : 4'b0000;
      check_val("wr4_ack", pe_ack_a, exp_ack);
      if (cyc % 3 == 1) begin
        check_val("wr4_mem_en", mem_en_a, 1'b1);
        check_val("wr4_wdata", mem_wdata_a, 32'h1000 + 32'(cyc / 3));
      end
      pe_req = pe_req & ~pe_ack_a;
    end
    check_val("wr4_mem3", mem_a[8'h0C], 32'h1003);

    // Round-robin between continuously requesting PE0 and PE3
    do_reset();
    pe_req = 4'b1001; pe_we = 4'b1001;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(negedge clk);
      if (cyc % 3 == 1) check_val("rr_grant", grant_a, fair_order[cyc / 3]);
    end
    pe_req = 4'h0;

    // RD_LAT=3 read on instance b, PE1 at 0x44
    do_reset();
    pe_req = 4'b0010; pe_we = 4'b0000; pe_addr[1*32 +: 32] = 32'h44;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      @(negedge clk);
      check_val("lat3_busy", busy_b, (cyc <= 5) ? 1'b1 : 1'b0);
      check_val("lat3_ack", pe_ack_b, (cyc == 5) ? 4'b0010 : 4'b0000);
      if (cyc == 1) check_val("lat3_mem_en", mem_en_b, 1'b1);
      if (cyc == 5) begin
        check_val("lat3_data", pe_rdata_b, 32'h1234_5678);
        pe_req = 4'h0;
      end
    end

    // Reset during WAIT aborts the read; pointer returns to 0
    do_reset();
    pe_req = 4'b0100; pe_we = 4'b0000; pe_addr[2*32 +: 32] = 32'h40;
    @(negedge clk);
    @(negedge clk);
    check_val("abort_busy_pre", busy_a, 1'b1);
    reset = 1'b1;
    pe_req = 4'h0;
    #1;
    check_val("abort_grant", grant_a, 4'h0);
    check_val("abort_busy", busy_a, 1'b0);
    check_val("abort_mem_addr", mem_addr_a, 32'h0);
    check_val("abort_ack", pe_ack_a, 4'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_val("abort_no_ack", pe_ack_a, 4'h0);
    pe_req = 4'b0101; pe_we = 4'b0101;
    @(negedge clk);
    check_val("abort_ptr0", grant_a, 4'b0001);
    pe_req = 4'h0;

    // Dropped request and changed fields after grant
    do_reset();
    pe_req = 4'b0010; pe_we = 4'b0010;
    pe_addr[1*32 +: 32] = 32'h8; pe_wdata[1*32 +: 32] = 32'hAA;
    @(negedge clk);
    check_val("drop_mem_addr", mem_addr_a, 32'h8);
    check_val("drop_mem_we", mem_we_a, 1'b1);
    pe_req = 4'h0; pe_addr[1*32 +: 32] = 32'h10; pe_wdata[1*32 +: 32] = 32'h55;
    @(negedge clk);
    check_val("drop_ack", pe_ack_a, 4'b0010);
    @(negedge clk);
    check_val("drop_mem8", mem_a[8'h08], 32'hAA);
    check_val("drop_mem10", mem_a[8'h10], 32'h0);
    check_val("drop_idle", busy_a, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cgra_mem_arbiter.md
Name: cgra_mem_arbiter

Overview:
- Round-robin arbiter and transaction sequencer for the CGRA shared memory; 4 PE requesters share one single-ported memory.
- Grants one PE at a time, drives the memory port from latched request fields and waits the fixed memory read latency.
- Returns read data and a one-cycle completion ack to the granted PE.
- Sits between the PE bus interfaces and the shared memory instance in the bus system.

Parameters:
- N_PE, 4, number of requesters; the design is fixed at 4, and only 4 is supported.
- AW, 32, address width.
- DW, 32, data width.
- RD_LAT, 1, memory read latency in cycles from the mem_en cycle to mem_rdata valid; must be at least 1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- pe_req  in  4  per-PE request; held high until that PE's ack.
- pe_we  in  4  per-PE write flag; 1 = write, 0 = read; valid while pe_req is high.
- pe_addr  in  4*AW  packed addresses; PE i occupies bits [i*AW +: AW].
- pe_wdata  in  4*DW  packed write data; same packing as pe_addr.
- pe_ack  out  4  one-hot, one-cycle completion pulse.
- pe_rdata  out  DW  registered read data; valid in the pe_ack cycle of a read.
- grant  out  4  one-hot owner of the current transaction; 0 when idle.
- busy  out  1  high in any state other than IDLE.
- mem_en  out  1  memory access strobe; exactly one cycle per transaction.
- mem_we  out  1  memory write enable; qualified by mem_en.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data; valid RD_LAT cycles after the mem_en cycle.

Behaviour:
- Reset (async):
  - State = IDLE; rr_ptr = 0.
  - grant, pe_ack, pe_rdata, mem_en, mem_we, mem_addr, mem_wdata, busy all = 0.
  - A reset mid-transaction aborts it: no ack is issued and mem_en drops immediately.
- State machine: IDLE -> ISSUE -> (WAIT if read) -> DONE -> IDLE.
- IDLE:
  - If pe_req != 0, select the first requester at or after rr_ptr, wrapping 3 -> 0.
  - Latch its index, we, addr and wdata; set grant; rr_ptr <= winner + 1 (mod 4). Go to ISSUE.
  - pe_req is sampled only in IDLE.
- ISSUE (1 cycle):
  - mem_en = 1; mem_we, mem_addr, mem_wdata come from the latched fields.
  - Go to DONE if write; go to WAIT with cnt = RD_LAT - 1 if read.
- WAIT (RD_LAT cycles):
  - cnt decrements each cycle.
  - At cnt == 0, capture mem_rdata into pe_rdata and go to DONE.
- DONE (1 cycle):
  - pe_ack[grant index] = 1; pe_rdata stays valid (a write leaves it unchanged).
  - Next state IDLE; grant clears on entering IDLE.
- Latency, with the request seen in IDLE at cycle 0:
  - Write: mem_en at cycle 1, ack at cycle 2.
  - Read: mem_en at cycle 1, ack at cycle 2 + RD_LAT (cycle 3 at default).
- Back-to-back: minimum 3 cycles per write and 3 + RD_LAT per read; there is one IDLE cycle between transactions.
- Requester rules:
  - Deassert pe_req in the cycle after ack, unless issuing a new request.
  - A req still high in the IDLE cycle after ack counts as a new request.
- Edge cases:
  - Dropping pe_req mid-transaction does not cancel it; the access completes and ack still pulses.
  - pe_we, pe_addr and pe_wdata changes after the grant are ignored, because the fields are latched.
  - pe_we is ignored when the matching pe_req is 0.
- Fairness: a continuously requesting PE waits at most 3 other transactions before its grant.
- Invariants: grant and pe_ack are always zero or one-hot; pe_ack is set only at grant's bit position.

Test Plan:
- Read, single requester: RD_LAT=1, mem holds 0xDEADBEEF at 0x40; PE2 reads 0x40 at cycle 0 -> mem_en=1, mem_we=0, mem_addr=0x40 at cycle 1; pe_ack=4'b0100 and pe_rdata=0xDEADBEEF at cycle 3.
- Simultaneous writes: all 4 PEs write at cycle 0, PE i data = 0x1000+i -> acks for PE0..PE3 at cycles 2, 5, 8, 11; mem_wdata = 0x1000..0x1003 in order.
- Round-robin fairness: PE0 and PE3 request continuously with writes -> grant order 0, 3, 0, 3 and never two consecutive grants to PE0.
- Read latency: RD_LAT=3, PE1 read -> mem_en at cycle 1, data captured at end of cycle 4, pe_ack=4'b0010 at cycle 5; busy high for cycles 1-5.
- Reset mid-read: assert reset in WAIT -> all outputs 0 the same cycle, no ack; after release, a PE0 request gets its grant first (rr_ptr=0).
- Request dropped and fields changed: PE1 write to 0x8 with data 0xAA; drop pe_req and change pe_addr in ISSUE -> memory writes 0xAA to 0x8; ack still pulses at cycle 2.
